// File: rtl/sym9_pkg.sv
// Shared constants, state encoding and golden model for the sym9 activity monitor.
package sym9_pkg;

  localparam int NUM_IN       = 9;
  localparam int NUM_ENTRIES  = 12;
  localparam int IDX_OUT_TGL  = 9;
  localparam int IDX_OUT_ONES = 10;
  localparam int IDX_MISMATCH = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REPORT  = 2'd2
  } state_e;

  // Reference behaviour of the 9-input symmetric benchmark: high when 3..6 inputs are high.
  function automatic logic sym9_golden(input logic [NUM_IN-1:0] vec);
    logic [3:0] ones;
    ones = 4'd0;
    for (int i = 0; i < NUM_IN; i++) begin
      ones = ones + {3'd0, vec[i]};
    end
    return (ones >= 4'd3) && (ones <= 4'd6);
  endfunction

endpackage

// File: rtl/sym9_activity_monitor_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping; clr wins over inc.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] q_d;
  logic [CNT_W-1:0] q_q;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {CNT_W{1'b1}})) begin
      q_d = q_q + CNT_W'(1);
    end else begin
      q_d = q_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sym9_activity_monitor.sv
// Activity monitor for the sym9 benchmark: collects toggle/ones/mismatch counts
// over WINDOW samples, then streams 12 report entries over valid/ready.
module sym9_activity_monitor
  import sym9_pkg::*;
#(
  parameter int WINDOW = 1024,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [8:0]        in_vec,
  input  logic              in_res,
  output logic              busy,
  output logic              done,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [3:0]        rpt_idx,
  output logic [CNT_W-1:0]  rpt_count
);

  localparam int              SMP_W    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(WINDOW - 1);
  localparam logic [3:0]      LAST_IDX = 4'(NUM_ENTRIES - 1);

  state_e             state_q, state_d;
  logic [SMP_W-1:0]   smp_q, smp_d;
  logic [NUM_IN-1:0]  prev_vec_q, prev_vec_d;
  logic               prev_res_q, prev_res_d;
  logic               prev_valid_q, prev_valid_d;
  logic               rpt_valid_q, rpt_valid_d;
  logic [3:0]         rpt_idx_q, rpt_idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic                   sample_s;
  logic                   rpt_fire_s;
  logic                   cnt_clr_s;
  logic [NUM_ENTRIES-1:0] cnt_inc_s;
  logic [CNT_W-1:0]       cnt_q [NUM_ENTRIES];

  assign sample_s   = (state_q == ST_COLLECT) && in_valid;
  assign rpt_fire_s = rpt_valid_q && rpt_ready;
  assign cnt_clr_s  = (state_q == ST_IDLE) && start;

  // Per-sample increment requests; toggles only once a previous sample exists.
  always_comb begin
    cnt_inc_s = '0;
    if (sample_s) begin
      for (int i = 0; i < NUM_IN; i++) begin
        cnt_inc_s[i] = prev_valid_q && (in_vec[i] != prev_vec_q[i]);
      end
      cnt_inc_s[IDX_OUT_TGL]  = prev_valid_q && (in_res != prev_res_q);
      cnt_inc_s[IDX_OUT_ONES] = in_res;
      cnt_inc_s[IDX_MISMATCH] = (in_res != sym9_golden(in_vec));
    end else begin
      cnt_inc_s = '0;
    end
  end

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr_s),
      .inc (cnt_inc_s[g]),
      .q   (cnt_q[g])
    );
  end

  // Next-state, sample bookkeeping and report sequencing.
  always_comb begin
    state_d      = state_q;
    smp_d        = smp_q;
    prev_vec_d   = prev_vec_q;
    prev_res_d   = prev_res_q;
    prev_valid_d = prev_valid_q;
    rpt_idx_d    = rpt_idx_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_COLLECT;
          smp_d        = '0;
          prev_valid_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (sample_s) begin
          prev_vec_d   = in_vec;
          prev_res_d   = in_res;
          prev_valid_d = 1'b1;
          if (smp_q == SMP_LAST) begin
            state_d   = ST_REPORT;
            rpt_idx_d = 4'd0;
            smp_d     = '0;
          end else begin
            smp_d = smp_q + SMP_W'(1);
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_REPORT: begin
        if (rpt_fire_s) begin
          if (rpt_idx_q == LAST_IDX) begin
            state_d   = ST_IDLE;
            rpt_idx_d = 4'd0;
            done_d    = 1'b1;
          end else begin
            rpt_idx_d = rpt_idx_q + 4'd1;
          end
        end else begin
          state_d = ST_REPORT;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rpt_idx_d = 4'd0;
      end
    endcase
    rpt_valid_d = (state_d == ST_REPORT);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      smp_q        <= '0;
      prev_vec_q   <= '0;
      prev_res_q   <= 1'b0;
      prev_valid_q <= 1'b0;
      rpt_valid_q  <= 1'b0;
      rpt_idx_q    <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      smp_q        <= smp_d;
      prev_vec_q   <= prev_vec_d;
      prev_res_q   <= prev_res_d;
      prev_valid_q <= prev_valid_d;
      rpt_valid_q  <= rpt_valid_d;
      rpt_idx_q    <= rpt_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Report mux: indexed read of the (frozen) counter registers, zero when idle.
  assign rpt_count = (rpt_valid_q && (rpt_idx_q <= LAST_IDX)) ? cnt_q[rpt_idx_q] : '0;
  assign rpt_valid = rpt_valid_q;
  assign rpt_idx   = rpt_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sym9_activity_monitor.sv
// Scoreboard bench: unit A (WINDOW=4, CNT_W=16) and unit B (WINDOW=20, CNT_W=4)
// share stimulus; only the started unit collects.
module tb_sym9_activity_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b, in_valid, in_res, rpt_ready;
  logic [8:0]  in_vec;
  logic        busy_a, done_a, rv_a, busy_b, done_b, rv_b;
  logic [3:0]  idx_a, idx_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int total = 0;
  int bad   = 0;
  int done_seen = 0;
  int done_exp  = 0;

  logic [8:0] sv_q[$];
  logic       sr_q[$];
  int         exp_idx_q[$];
  int         exp_val_q[$];

  sym9_activity_monitor #(.WINDOW(4), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_vec(in_vec),
    .in_res(in_res), .busy(busy_a), .done(done_a), .rpt_valid(rv_a),
    .rpt_ready(rpt_ready), .rpt_idx(idx_a), .rpt_count(cnt_a)
  );

  sym9_activity_monitor #(.WINDOW(20), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_vec(in_vec),
    .in_res(in_res), .busy(busy_b), .done(done_b), .rpt_valid(rv_b),
    .rpt_ready(rpt_ready), .rpt_idx(idx_b), .rpt_count(cnt_b)
  );

  // Count done pulses from either unit.
  always @(posedge clk) begin
    if (!rst && (done_a || done_b)) done_seen <= done_seen + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic int f_busy(int u); return u != 0 ? int'(busy_b) : int'(busy_a); endfunction
  function automatic int f_done(int u); return u != 0 ? int'(done_b) : int'(done_a); endfunction
  function automatic int f_rv(int u);   return u != 0 ? int'(rv_b)   : int'(rv_a);   endfunction
  function automatic int f_idx(int u);  return u != 0 ? int'(idx_b)  : int'(idx_a);  endfunction
  function automatic int f_cnt(int u);  return u != 0 ? int'(cnt_b)  : int'(cnt_a);  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_start(input int u, input logic v);
    if (u != 0) start_b = v;
    else start_a = v;
  endtask

  // Reference counts for the queued samples, pushed to the scoreboard.
  task automatic model_push(input int u);
    int cnt[12];
    int maxv;
    int pc;
    logic g;
    maxv = (u != 0) ? 15 : 65535;
    for (int k = 0; k < 12; k++) cnt[k] = 0;
    for (int j = 0; j < sv_q.size(); j++) begin
      pc = $countones(sv_q[j]);
      g  = (pc >= 3 && pc <= 6);
      if (sr_q[j] != g) cnt[11]++;
      if (sr_q[j]) cnt[10]++;
      if (j > 0) begin
        for (int i = 0; i < 9; i++) if (sv_q[j][i] != sv_q[j-1][i]) cnt[i]++;
        if (sr_q[j] != sr_q[j-1]) cnt[9]++;
      end
    end
    for (int k = 0; k < 12; k++) begin
      exp_idx_q.push_back(k);
      exp_val_q.push_back(cnt[k] > maxv ? maxv : cnt[k]);
    end
  endtask

  task automatic drain(input int u, input bit stall);
    int got = 0;
    int cyc = 0;
    bit stalled = 0;
    int hidx, hval, e_i, e_v;
    rpt_ready = 1'b1;
    while (got < 12 && cyc < 100) begin
      if (stall && !stalled && f_rv(u) == 1 && f_idx(u) == 3) begin
        stalled = 1;
        rpt_ready = 1'b0;
        hidx = f_idx(u);
        hval = f_cnt(u);
        repeat (5) begin
          @(posedge clk); #1;
          chk("hold_valid", f_rv(u), 1);
          chk("hold_idx", f_idx(u), hidx);
          chk("hold_cnt", f_cnt(u), hval);
        end
        rpt_ready = 1'b1;
      end
      chk("rv_stream", f_rv(u), 1);
      if (f_rv(u) == 1 && exp_idx_q.size() > 0) begin
        e_i = exp_idx_q.pop_front();
        e_v = exp_val_q.pop_front();
        chk("entry_idx", f_idx(u), e_i);
        chk($sformatf("entry%0d_count", e_i), f_cnt(u), e_v);
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rpt_ready = 1'b0;
    if (got < 12) begin
      chk("drain_timeout", got, 12);
    end else begin
      chk("done_pulse", f_done(u), 1);
      chk("busy_off", f_busy(u), 0);
      @(posedge clk); #1;
      chk("done_clear", f_done(u), 0);
      chk("rv_off", f_rv(u), 0);
    end
  endtask

  // Start a window (with an uncounted sample in the start cycle), feed the queued samples, drain.
  task automatic run_window(input int u, input int gap, input bit stall);
    int n;
    n = sv_q.size();
    model_push(u);
    set_start(u, 1'b1);
    in_valid = 1'b1; in_vec = 9'h1FF; in_res = 1'b1;
    @(posedge clk); #1;
    set_start(u, 1'b0);
    in_valid = 1'b0;
    chk("busy_on", f_busy(u), 1);
    for (int j = 0; j < n; j++) begin
      in_valid = 1'b1; in_vec = sv_q[j]; in_res = sr_q[j];
      if (j == n - 1) chk("rv_early", f_rv(u), 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (j < n - 1) begin
        repeat (gap) begin
          set_start(u, 1'b1);
          in_vec = 9'h155; in_res = 1'b1;
          @(posedge clk); #1;
        end
        set_start(u, 1'b0);
      end
    end
    chk("rv_rise", f_rv(u), 1);
    chk("idx_first", f_idx(u), 0);
    drain(u, stall);
    done_exp++;
    sv_q.delete();
    sr_q.delete();
  endtask

  task automatic push_smp(input logic [8:0] v, input logic r);
    sv_q.push_back(v);
    sr_q.push_back(r);
  endtask

  initial begin
    logic [8:0] rv;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0;
    in_vec = 9'h000; in_res = 1'b0; rpt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_busy", f_busy(u), 0);
      chk("rst_done", f_done(u), 0);
      chk("rst_rv", f_rv(u), 0);
      chk("rst_idx", f_idx(u), 0);
      chk("rst_cnt", f_cnt(u), 0);
    end
    rst = 1'b0;

    // samples offered while idle are ignored
    in_valid = 1'b1; in_vec = 9'h0F0; in_res = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    chk("idle_busy", f_busy(0), 0);

    // full toggle pattern
    push_smp(9'h000, 1'b0); push_smp(9'h1FF, 1'b0);
    push_smp(9'h000, 1'b0); push_smp(9'h1FF, 1'b0);
    run_window(0, 0, 1'b0);

    // golden mismatch / ones / output toggles
    push_smp(9'h007, 1'b0); push_smp(9'h007, 1'b1);
    push_smp(9'h03F, 1'b1); push_smp(9'h07F, 1'b0);
    run_window(0, 0, 1'b0);

    // gaps between samples, start held high during gaps
    push_smp(9'h000, 1'b0); push_smp(9'h1FF, 1'b0);
    push_smp(9'h000, 1'b0); push_smp(9'h1FF, 1'b0);
    run_window(0, 3, 1'b0);

    // random samples with occasional wrong results, consumer stall at idx 3
    for (int j = 0; j < 4; j++) begin
      rv = 9'($urandom_range(0, 511));
      push_smp(rv, (($countones(rv) >= 3) && ($countones(rv) <= 6)) ^ ($urandom_range(0, 2) == 0));
    end
    run_window(0, 0, 1'b1);

    // saturation on the narrow unit
    for (int j = 0; j < 20; j++) push_smp((j % 2 == 0) ? 9'h001 : 9'h000, 1'b0);
    run_window(1, 0, 1'b0);

    // abort mid-window with reset, then a fresh window
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    in_valid = 1'b1; in_vec = 9'h1FF; in_res = 1'b1;
    @(posedge clk); #1;
    in_vec = 9'h0F0; in_res = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", f_busy(0), 0);
    chk("abort_rv", f_rv(0), 0);
    chk("abort_done", f_done(0), 0);
    rst = 1'b0;
    push_smp(9'h00F, 1'b1); push_smp(9'h01F, 1'b1);
    push_smp(9'h000, 1'b1); push_smp(9'h0FF, 1'b0);
    run_window(0, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("done_count", done_seen, done_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
